join_any_i2c_slave: RTL and testbench

- Synthesizable I2C target (slave) front end. Oversamples SCL/SDA on the system clock and decodes START, STOP, the address byte, write bytes and read bytes.
- Drives ACK and read data onto SDA through an open-drain enable.
- During every data byte it races three watchers: byte-complete, repeated START and STOP. Whichever fires first ends the byte (join_any semantics) and is reported on evt_o.
- Sits between the I2C pads and a register/FIFO back end.

---
 rtl/join_any_i2c_pkg.sv | 38 +++
 rtl/i2c_cond_detect.sv | 42 ++++
 rtl/join_any_i2c_slave.sv | 182 ++++++++++++++++++
 tb/tb_join_any_i2c_slave.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/join_any_i2c_pkg.sv
//////////////////////////////////////////////////////////////////////
// join_any_i2c_pkg - shared types for the join_any I2C target
// Revision: 1.0
//////////////////////////////////////////////////////////////////////
`default_nettype none

package join_any_i2c_pkg;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'd0,
    EVT_BYTE  = 2'd1,
    EVT_START = 2'd2,
    EVT_STOP  = 2'd3
  } evt_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_DATA  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_DATA  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_cond_detect.sv
//////////////////////////////////////////////////////////////////////
// i2c_cond_detect - SCL/SDA synchronizers, SCL edges, START/STOP
// Revision: 1.0
//////////////////////////////////////////////////////////////////////
`default_nettype none

module i2c_cond_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  // [0] metastability FF, [1] synchronized level, [2] history
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '0;
      sda_q <= '0;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign sda_o      = sda_q[1];
  assign scl_rise_o = scl_q[1] & ~scl_q[2];
  assign scl_fall_o = ~scl_q[1] & scl_q[2];
  // SCL must be high in both samples so the post-reset ramp of both lines is not a STOP
  assign start_o    = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_o     = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

endmodule

`default_nettype wire

// File: rtl/join_any_i2c_slave.sv
//////////////////////////////////////////////////////////////////////
// join_any_i2c_slave - I2C target front end; START/STOP/byte race per data byte
// Revision: 1.0
//////////////////////////////////////////////////////////////////////
`default_nettype none

module join_any_i2c_slave
  import join_any_i2c_pkg::*;
#(
  parameter int                        I2C_ADDR_WIDTH = 7,
  parameter int                        I2C_DATA_WIDTH = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] ADDRESS        = 7'h22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      scl_i,
  input  logic                      sda_i,
  output logic                      sda_oe,
  output logic                      start_o,
  output logic                      stop_o,
  output logic [I2C_ADDR_WIDTH-1:0] addr_o,
  output logic                      op_o,
  output logic                      addr_valid_o,
  output logic                      addr_match_o,
  output logic [I2C_DATA_WIDTH-1:0] wr_data_o,
  output logic                      wr_valid_o,
  output logic                      rd_req_o,
  input  logic [I2C_DATA_WIDTH-1:0] rd_data_i,
  output logic                      rd_nack_o,
  output logic [1:0]                evt_o,
  output logic                      busy_o
);

  localparam int CNT_W = $clog2(max_int(I2C_ADDR_WIDTH + 1, I2C_DATA_WIDTH) + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(I2C_ADDR_WIDTH);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(I2C_DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_DONE = CNT_W'(I2C_DATA_WIDTH);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_cond_detect u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_o     (w_sda),
    .scl_rise_o(w_scl_rise),
    .scl_fall_o(w_scl_fall),
    .start_o   (w_start),
    .stop_o    (w_stop)
  );

  state_t                    state_q;
  evt_t                      evt_q;
  i2c_op_t                   op_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [I2C_ADDR_WIDTH-1:0] addr_sh_q, addr_q;
  logic [I2C_DATA_WIDTH-1:0] data_sh_q, wr_data_q, rd_sh_q;
  logic oe_q, start_q, stop_q, addr_valid_q, match_q, wr_valid_q;
  logic rd_req_q, rd_nack_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;      evt_q <= EVT_NONE;   op_q <= I2C_WRITE;
      cnt_q <= '0;             addr_sh_q <= '0;     addr_q <= '0;
      data_sh_q <= '0;         wr_data_q <= '0;     rd_sh_q <= '0;
      oe_q <= 1'b0;            start_q <= 1'b0;     stop_q <= 1'b0;
      addr_valid_q <= 1'b0;    match_q <= 1'b0;     wr_valid_q <= 1'b0;
      rd_req_q <= 1'b0;        rd_nack_q <= 1'b0;   busy_q <= 1'b0;
    end else begin
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      addr_valid_q <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_nack_q    <= 1'b0;
      if (rd_req_q) rd_sh_q <= rd_data_i;

      if (w_stop) begin
        state_q <= ST_IDLE;  oe_q <= 1'b0;  stop_q <= 1'b0 | 1'b1;
        busy_q  <= 1'b0;     match_q <= 1'b0;
        evt_q   <= EVT_STOP; cnt_q <= '0;
      end else if (w_start) begin
        state_q <= ST_ADDR;  oe_q <= 1'b0;  start_q <= 1'b1;
        busy_q  <= 1'b1;     evt_q <= EVT_START;  cnt_q <= '0;
      end else begin
        case (state_q)
          ST_ADDR: if (w_scl_rise) begin
            if (cnt_q == ADDR_LAST) begin
              addr_q       <= addr_sh_q;
              op_q         <= i2c_op_t'(w_sda);
              addr_valid_q <= 1'b1;
              match_q      <= (addr_sh_q == ADDRESS);
              cnt_q        <= '0;
              if (addr_sh_q == ADDRESS) begin
                state_q  <= ST_ADDR_ACK;
                rd_req_q <= w_sda;
              end else begin
                state_q <= ST_IGNORE;
              end
            end else begin
              addr_sh_q <= {addr_sh_q[I2C_ADDR_WIDTH-2:0], w_sda};
              cnt_q     <= cnt_q + 1'b1;
            end
          end
          // oe_q doubles as the ACK phase flag: first fall drives, second fall ends
          ST_ADDR_ACK, ST_WR_ACK: if (w_scl_fall) begin
            if (!oe_q) begin
              oe_q <= 1'b1;
            end else if (state_q == ST_ADDR_ACK && op_q == I2C_READ) begin
              state_q <= ST_RD_DATA;
              oe_q    <= ~rd_sh_q[I2C_DATA_WIDTH-1];
              cnt_q   <= '0;
            end else begin
              state_q <= ST_WR_DATA;
              oe_q    <= 1'b0;
              cnt_q   <= '0;
            end
          end
          ST_WR_DATA: if (w_scl_rise) begin
            if (cnt_q == DATA_LAST) begin
              wr_data_q  <= {data_sh_q[I2C_DATA_WIDTH-2:0], w_sda};
              wr_valid_q <= 1'b1;
              evt_q      <= EVT_BYTE;
              state_q    <= ST_WR_ACK;
              cnt_q      <= '0;
            end else begin
              data_sh_q <= {data_sh_q[I2C_DATA_WIDTH-2:0], w_sda};
              cnt_q     <= cnt_q + 1'b1;
            end
          end
          // cnt_q counts bits already clocked out; MSB is driven at cnt_q == 0
          ST_RD_DATA: begin
            if (w_scl_rise) begin
              cnt_q <= cnt_q + 1'b1;
            end else if (w_scl_fall) begin
              if (cnt_q == DATA_DONE) begin
                oe_q    <= 1'b0;
                state_q <= ST_RD_ACK;
                cnt_q   <= '0;
              end else if (cnt_q == '0) begin
                oe_q <= ~rd_sh_q[I2C_DATA_WIDTH-1];
              end else begin
                oe_q    <= ~rd_sh_q[I2C_DATA_WIDTH-2];
                rd_sh_q <= {rd_sh_q[I2C_DATA_WIDTH-2:0], 1'b0};
              end
            end
          end
          ST_RD_ACK: if (w_scl_rise) begin
            evt_q <= EVT_BYTE;
            cnt_q <= '0;
            if (!w_sda) begin
              rd_req_q <= 1'b1;
              state_q  <= ST_RD_DATA;
            end else begin
              rd_nack_q <= 1'b1;
              state_q   <= ST_IGNORE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign sda_oe       = oe_q;
  assign start_o      = start_q;
  assign stop_o       = stop_q;
  assign addr_o       = addr_q;
  assign op_o         = op_q;
  assign addr_valid_o = addr_valid_q;
  assign addr_match_o = match_q;
  assign wr_data_o    = wr_data_q;
  assign wr_valid_o   = wr_valid_q;
  assign rd_req_o     = rd_req_q;
  assign rd_nack_o    = rd_nack_q;
  assign evt_o        = evt_q;
  assign busy_o       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_join_any_i2c_slave.sv
//////////////////////////////////////////////////////////////////////
// tb_join_any_i2c_slave - bus-level I2C controller model with directed and random transfers
// Revision: 1.0
//////////////////////////////////////////////////////////////////////
`default_nettype none

module tb_join_any_i2c_slave;
  import join_any_i2c_pkg::*;

  localparam int H = 8;  // SCL half period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic [7:0] rd_data_i = 8'h00;

  logic       sda_oe, start_o, stop_o, op_o, addr_valid_o, addr_match_o;
  logic       wr_valid_o, rd_req_o, rd_nack_o, busy_o;
  logic [6:0] addr_o;
  logic [7:0] wr_data_o;
  logic [1:0] evt_o;

  assign sda_bus = sda_m & ~sda_oe;

  join_any_i2c_slave dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .start_o     (start_o),
    .stop_o      (stop_o),
    .addr_o      (addr_o),
    .op_o        (op_o),
    .addr_valid_o(addr_valid_o),
    .addr_match_o(addr_match_o),
    .wr_data_o   (wr_data_o),
    .wr_valid_o  (wr_valid_o),
    .rd_req_o    (rd_req_o),
    .rd_data_i   (rd_data_i),
    .rd_nack_o   (rd_nack_o),
    .evt_o       (evt_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // observed back-end activity
  logic [7:0] wr_got[$];
  logic [7:0] rd_src[$];
  int n_addr_valid, n_rd_req, n_nack, n_start, n_stop;
  logic oe_seen;

  always @(negedge clk) begin
    if (wr_valid_o) wr_got.push_back(wr_data_o);
    if (addr_valid_o) n_addr_valid++;
    if (rd_nack_o) n_nack++;
    if (start_o) n_start++;
    if (stop_o) n_stop++;
    if (sda_oe) oe_seen = 1'b1;
    if (rd_req_o) begin
      n_rd_req++;
      rd_data_i = (rd_src.size() > 0) ? rd_src.pop_front() : 8'hFF;
    end
  end

  task automatic clr();
    wr_got.delete(); rd_src.delete();
    n_addr_valid = 0; n_rd_req = 0; n_nack = 0; n_start = 0; n_stop = 0;
    oe_seen = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(H/2); sda_m = b; tick(H/2); scl = 1'b1; tick(H); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(H/2); sda_m = 1'b1; tick(H/2); scl = 1'b1; tick(H/2); b = sda_bus; tick(H/2); scl = 1'b0;
  endtask

  task automatic i2c_start();
    if (scl == 1'b0) begin
      tick(H/2); sda_m = 1'b1; tick(H/2); scl = 1'b1; tick(H/2);
    end else begin
      tick(H/2);
    end
    sda_m = 1'b0; tick(H/2); scl = 1'b0;
  endtask

  task automatic i2c_stop();
    tick(H/2); sda_m = 1'b0; tick(H/2); scl = 1'b1; tick(H/2); sda_m = 1'b1; tick(H);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic b;
    d = '0;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  function automatic logic [7:0] wr_at(input int i);
    return (i < wr_got.size()) ? wr_got[i] : 8'hxx;
  endfunction

  // Reference: a target at 0x22 ACKs and reports every write byte and serves
  // read bytes from the back end; any other address leaves the bus released.
  task automatic random_txn(input int k);
    logic [6:0] a;
    logic       op, ack, match;
    logic [7:0] dat[3];
    logic [7:0] got;
    int         n;
    a = 7'($urandom_range(0, 127));
    if ($urandom_range(0, 1) == 1) a = 7'h22;
    op = 1'($urandom_range(0, 1));
    n  = $urandom_range(1, 3);
    foreach (dat[i]) dat[i] = 8'($urandom);
    match = (a == 7'h22);
    clr();
    if (op && match) for (int i = 0; i < n; i++) rd_src.push_back(dat[i]);
    i2c_start();
    write_byte({a, op}, ack);
    check($sformatf("rnd%0d addr_ack", k), ack, match);
    check($sformatf("rnd%0d addr_o", k), addr_o, a);
    check($sformatf("rnd%0d op_o", k), op_o, op);
    check($sformatf("rnd%0d addr_match", k), addr_match_o, match);
    for (int i = 0; i < n; i++) begin
      if (!op) begin
        write_byte(dat[i], ack);
        check($sformatf("rnd%0d data_ack%0d", k, i), ack, match);
      end else begin
        read_byte(i == n - 1, got);
        check($sformatf("rnd%0d rd_byte%0d", k, i), got, match ? dat[i] : 8'hFF);
      end
    end
    i2c_stop();
    check($sformatf("rnd%0d wr_count", k), wr_got.size(), (!op && match) ? n : 0);
    if (!op && match)
      for (int i = 0; i < n; i++) check($sformatf("rnd%0d wr_data%0d", k, i), wr_at(i), dat[i]);
    check($sformatf("rnd%0d rd_req", k), n_rd_req, (op && match) ? n : 0);
    check($sformatf("rnd%0d rd_nack", k), n_nack, (op && match) ? 1 : 0);
    check($sformatf("rnd%0d oe_seen", k), oe_seen, match);
    check($sformatf("rnd%0d evt", k), evt_o, EVT_STOP);
    check($sformatf("rnd%0d busy", k), busy_o, 1'b0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] got;

    // reset state
    clr();
    tick(3);
    check("reset_outputs", {start_o, stop_o, addr_o, op_o, addr_valid_o, addr_match_o, wr_data_o,
                            wr_valid_o, rd_req_o, rd_nack_o, evt_o, busy_o, sda_oe}, '0);
    rst_n = 1'b1;
    tick(10);
    check("idle_no_events", n_start + n_stop, 0);

    // write 0xA5, 0x3C to own address
    clr();
    i2c_start();
    check("t1 busy", busy_o, 1'b1);
    write_byte(8'h44, ack);
    check("t1 addr_ack", ack, 1'b1);
    check("t1 addr_o", addr_o, 7'h22);
    check("t1 match", addr_match_o, 1'b1);
    check("t1 evt_start", evt_o, EVT_START);
    write_byte(8'hA5, ack);
    check("t1 ack0", ack, 1'b1);
    check("t1 evt_byte", evt_o, EVT_BYTE);
    write_byte(8'h3C, ack);
    check("t1 ack1", ack, 1'b1);
    i2c_stop();
    check("t1 wr_count", wr_got.size(), 2);
    check("t1 wr0", wr_at(0), 8'hA5);
    check("t1 wr1", wr_at(1), 8'h3C);
    check("t1 stop", n_stop, 1);
    check("t1 evt_stop", evt_o, EVT_STOP);
    check("t1 busy_off", busy_o, 1'b0);
    check("t1 match_clr", addr_match_o, 1'b0);

    // foreign address 0x23
    clr();
    i2c_start();
    write_byte(8'h46, ack);
    check("t2 addr_nack", ack, 1'b0);
    check("t2 match", addr_match_o, 1'b0);
    check("t2 addr_valid", n_addr_valid, 1);
    write_byte(8'h55, ack);
    i2c_stop();
    check("t2 oe_never", oe_seen, 1'b0);
    check("t2 wr_count", wr_got.size(), 0);
    check("t2 busy_off", busy_o, 1'b0);

    // read 0x5A (ACK) then 0xF0 (NACK)
    clr();
    rd_src.push_back(8'h5A);
    rd_src.push_back(8'hF0);
    i2c_start();
    write_byte(8'h45, ack);
    check("t3 addr_ack", ack, 1'b1);
    check("t3 op", op_o, 1'b1);
    read_byte(1'b0, got);
    check("t3 rd0", got, 8'h5A);
    read_byte(1'b1, got);
    check("t3 rd1", got, 8'hF0);
    check("t3 evt_byte", evt_o, EVT_BYTE);
    i2c_stop();
    check("t3 rd_req", n_rd_req, 2);
    check("t3 rd_nack", n_nack, 1);

    // repeated START three bits into the second write byte
    clr();
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h11, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    i2c_start();
    check("t4 evt_start", evt_o, EVT_START);
    check("t4 busy", busy_o, 1'b1);
    write_byte(8'h44, ack);
    check("t4 addr_ack", ack, 1'b1);
    check("t4 addr_valid", n_addr_valid, 2);
    check("t4 starts", n_start, 2);
    i2c_stop();
    check("t4 wr_count", wr_got.size(), 1);
    check("t4 wr0", wr_at(0), 8'h11);

    // STOP five bits into a write byte
    clr();
    i2c_start();
    write_byte(8'h44, ack);
    for (int i = 0; i < 5; i++) send_bit(1'(i & 1));
    i2c_stop();
    check("t5 wr_count", wr_got.size(), 0);
    check("t5 evt_stop", evt_o, EVT_STOP);
    check("t5 busy_off", busy_o, 1'b0);

    // reset asserted while the address ACK is driven
    clr();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h44 >> i));
    tick(6);
    check("t6 ack_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6 oe_released", sda_oe, 1'b0);
    check("t6 outputs_zero", {start_o, stop_o, addr_o, op_o, addr_valid_o, addr_match_o, wr_data_o,
                              wr_valid_o, rd_req_o, rd_nack_o, evt_o, busy_o}, '0);
    tick(2);
    sda_m = 1'b1;
    tick(2);
    scl = 1'b1;
    tick(4);
    rst_n = 1'b1;
    tick(10);

    for (int k = 0; k < 8; k++) random_txn(k);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
